// File: rtl/mmio_bus_responder.sv
// mmio_bus_responder: 8-word MMIO target (LED, switches, cycle counter, countdown timer, scratch) on the CPU word bus
module mmio_bus_responder #(
  parameter logic [6:0] BASE_ADDR = 7'd120,
  parameter int         PRESCALE  = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CS,
  input  logic        WE,
  input  logic [6:0]  ADDR,
  inout  wire  [31:0] Mem_Bus,
  input  logic [7:0]  SW,
  output logic [7:0]  led,
  output logic        io_hit,
  output logic        irq
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state_q, state_d;
  logic [7:0]  led_q, led_d, sw_meta_q, sw_sync_q;
  logic [31:0] data_out_q, data_out_d, cycle_q, cycle_d, tload_q, tload_d;
  logic [31:0] tcount_q, tcount_d, scratch_q, scratch_d, rdata;
  logic [15:0] pre_q, pre_d;
  logic        expired_q, expired_d, irq_en_q, irq_en_d;
  logic        rd, wr, running, tick;
  logic [2:0]  off;
  assign Mem_Bus = rd ? data_out_q : 32'bz;
  assign led = led_q;
  // Address decode, read mux and prescaler tick; kept apart from next-state logic so the bus drive never loops back
  always_comb begin
    io_hit  = ADDR[6:3] == BASE_ADDR[6:3];
    off     = ADDR[2:0];
    rd      = CS && !WE && io_hit;
    wr      = CS && WE && io_hit;
    running = state_q == RUN;
    tick    = running && pre_q == 16'(PRESCALE - 1);
    irq     = expired_q && irq_en_q;
    rdata   = off == 3'd0 ? {24'd0, led_q} :
              off == 3'd1 ? {24'd0, sw_sync_q} :
              off == 3'd2 ? cycle_q :
              off == 3'd3 ? tload_q :
              off == 3'd4 ? tcount_q :
              off == 3'd5 ? {29'd0, irq_en_q, running, expired_q} :
              off == 3'd6 ? scratch_q : 32'd0;
  end
  // Next state: a TLOAD write overrides any same-edge decrement or expiry, and an expiry set beats a W1C clear
  always_comb begin
    logic load, nz, expire;
    load       = wr && off == 3'd3;
    nz         = |Mem_Bus;
    expire     = load ? !nz : tick && tcount_q == 32'd1;
    led_d      = wr && off == 3'd0 ? Mem_Bus[7:0] : led_q;
    cycle_d    = wr && off == 3'd2 ? 32'd0 : cycle_q + 32'd1;
    tload_d    = load ? Mem_Bus : tload_q;
    tcount_d   = load ? (nz ? Mem_Bus : tcount_q) : tick ? tcount_q - 32'd1 : tcount_q;
    pre_d      = load ? 16'd0 : tick ? 16'd0 : running ? pre_q + 16'd1 : pre_q;
    state_d    = load ? (nz ? RUN : IDLE) : expire ? IDLE : state_q;
    expired_d  = expire || (expired_q && !(wr && off == 3'd5 && Mem_Bus[0]));
    irq_en_d   = wr && off == 3'd5 ? Mem_Bus[2] : irq_en_q;
    scratch_d  = wr && off == 3'd6 ? Mem_Bus : scratch_q;
    data_out_d = rd ? rdata : data_out_q;
  end
  // All state advances on the falling edge so read data is ready for the CPU's next rising edge
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      led_q      <= 8'd0;
      sw_meta_q  <= 8'd0;
      sw_sync_q  <= 8'd0;
      data_out_q <= 32'd0;
      cycle_q    <= 32'd0;
      tload_q    <= 32'd0;
      tcount_q   <= 32'd0;
      scratch_q  <= 32'd0;
      pre_q      <= 16'd0;
      expired_q  <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      sw_meta_q  <= SW;
      sw_sync_q  <= sw_meta_q;
      data_out_q <= data_out_d;
      cycle_q    <= cycle_d;
      tload_q    <= tload_d;
      tcount_q   <= tcount_d;
      scratch_q  <= scratch_d;
      pre_q      <= pre_d;
      expired_q  <= expired_d;
      irq_en_q   <= irq_en_d;
    end
  end
endmodule

// File: tb/tb_mmio_bus_responder.sv
// tb_mmio_bus_responder: scoreboard bench with two responders (prescale 1 at 120, prescale 4 at 112) and a RAM stand-in
module tb_mmio_bus_responder;
  logic        CLK = 1'b0, RST, CS, WE, drv;
  logic [6:0]  ADDR;
  logic [7:0]  SW, led1, led4;
  logic [31:0] wdata;
  logic        hit1, hit4, irq1, irq4;
  wire  [31:0] Mem_Bus;
  logic [31:0] ram [0:127];
  int          n_chk = 0, n_fail = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];
  always #5 CLK = ~CLK;
  assign Mem_Bus = drv ? wdata : 32'bz;
  pullup (Mem_Bus);
  mmio_bus_responder #(.BASE_ADDR(7'd120), .PRESCALE(1)) u_p1 (
    .CLK(CLK), .RST(RST), .CS(CS), .WE(WE), .ADDR(ADDR), .Mem_Bus(Mem_Bus),
    .SW(SW), .led(led1), .io_hit(hit1), .irq(irq1));
  mmio_bus_responder #(.BASE_ADDR(7'd112), .PRESCALE(4)) u_p4 (
    .CLK(CLK), .RST(RST), .CS(CS), .WE(WE), .ADDR(ADDR), .Mem_Bus(Mem_Bus),
    .SW(SW), .led(led4), .io_hit(hit4), .irq(irq4));
  // RAM stand-in whose chip select is gated off inside the I/O windows
  always @(negedge CLK) begin
    if (RST) ram[126] <= 32'h1234_5678;
    else if (CS && WE && !hit1 && !hit4) ram[ADDR] <= Mem_Bus;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic bus(input logic cs, input logic we, input logic [6:0] a, input logic [31:0] d);
    #1;
    CS = cs; WE = we; ADDR = a; wdata = d; drv = cs && we;
    @(posedge CLK);
  endtask
  task automatic idle(input int n);
    repeat (n) bus(1'b0, 1'b0, 7'd0, 32'd0);
  endtask
  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    bus(1'b1, 1'b1, a, d);
  endtask
  task automatic rd(input string tag, input logic [6:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    bus(1'b1, 1'b0, a, 32'd0);
  endtask
  // Read data is taken at the rising edge that follows the capturing falling edge
  always @(posedge CLK) begin
    if (!RST && CS && !WE && (hit1 || hit4)) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
      else check(tag_q.pop_front(), Mem_Bus, exp_q.pop_front());
    end
  end
  initial begin
    RST = 1'b1; CS = 1'b0; WE = 1'b0; ADDR = 7'd0; SW = 8'd0; drv = 1'b0; wdata = 32'd0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK);
    check("led_rst", 32'(led1), 32'd0);
    check("irq_rst", 32'(irq1), 32'd0);
    rd("rsvd_rd", 7'd127, 32'd0);
    bus(1'b0, 1'b0, 7'd5, 32'd0);
    check("miss_hit", 32'(hit1), 32'd0);
    check("miss_z", Mem_Bus, 32'hFFFF_FFFF);
    bus(1'b0, 1'b0, 7'd127, 32'd0);
    check("nocs_hit", 32'(hit1), 32'd1);
    check("nocs_z", Mem_Bus, 32'hFFFF_FFFF);
    wr(7'd120, 32'h1A5);
    check("led_wr", 32'(led1), 32'hA5);
    rd("led_rd", 7'd120, 32'hA5);
    SW = 8'h3C;
    idle(1);
    rd("sw_sync2", 7'd121, 32'd0);
    rd("sw_sync3", 7'd121, 32'h3C);
    wr(7'd121, 32'hFF);
    rd("sw_ro", 7'd121, 32'h3C);
    wr(7'd125, 32'h4);
    wr(7'd123, 32'd5);
    rd("t1_run", 7'd125, 32'h6);
    idle(2);
    rd("t1_cnt", 7'd124, 32'd2);
    check("t1_irq_pre", 32'(irq1), 32'd0);
    rd("t1_exp_edge", 7'd125, 32'h6);
    check("t1_irq", 32'(irq1), 32'd1);
    rd("t1_status", 7'd125, 32'h5);
    rd("t1_tcount", 7'd124, 32'd0);
    wr(7'd125, 32'h5);
    check("t1_irq_clr", 32'(irq1), 32'd0);
    rd("t1_w1c", 7'd125, 32'h4);
    wr(7'd123, 32'd2);
    idle(1);
    wr(7'd125, 32'h5);
    check("set_wins_irq", 32'(irq1), 32'd1);
    rd("set_wins", 7'd125, 32'h5);
    wr(7'd115, 32'd3);
    idle(4);
    rd("p4_cnt", 7'd116, 32'd2);
    idle(5);
    rd("p4_e11", 7'd117, 32'h2);
    rd("p4_e12", 7'd117, 32'h2);
    rd("p4_e13", 7'd117, 32'h1);
    check("p4_irq", 32'(irq4), 32'd0);
    wr(7'd117, 32'h1);
    rd("p4_clr", 7'd117, 32'h0);
    wr(7'd115, 32'd0);
    rd("p4_zero", 7'd117, 32'h1);
    wr(7'd117, 32'h1);
    wr(7'd115, 32'd2);
    idle(6);
    rd("p4_cnt1", 7'd116, 32'd1);
    wr(7'd115, 32'd10);
    rd("p4_reload", 7'd116, 32'd10);
    rd("p4_noexp", 7'd117, 32'h2);
    wr(7'd122, 32'h55);
    rd("cyc_clr", 7'd122, 32'd0);
    rd("cyc_inc", 7'd122, 32'd1);
    wr(7'd126, 32'hDEAD_BEEF);
    rd("scratch", 7'd126, 32'hDEAD_BEEF);
    rd("scratch_p4", 7'd118, 32'd0);
    check("ram_gated", ram[126], 32'h1234_5678);
    wr(7'd10, 32'hCAFE);
    check("ram_wr", ram[10], 32'hCAFE);
    idle(1);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
